// File: rtl/spi_wb_host.sv
// -----------------------------------------------------------------------------
// spi_wb_host
//
// SPI master (mode 3, MSB first) that issues framed bus transactions to the
// SPI-to-Wishbone slave bridge. One frame is:
//    cmd (0xA1 read / 0xA2 write), addr[31:0] MSB first, len[15:0] MSB first,
//    then a data phase of len + DUMMY_BYTES bytes.
// Chip select drops for every byte and rises again between bytes.
//
// Parameters
//    CLK_DIV     : SCLK half-period in i_clk cycles (>= 2)
//    GAP_CYCLES  : minimum i_clk cycles CS stays high between bytes (>= 1)
//    DUMMY_BYTES : extra 0x00 bytes in the data phase (0..7)
//
// Ports
//    i_clk, i_reset          : clock, synchronous active-high reset
//    i_start                 : start a frame when idle
//    i_write, i_addr, i_len  : frame type, bus address, payload length
//                              (sampled with i_start only)
//    i_wdata, i_wvalid       : write payload byte and its valid
//    o_wready                : i_wdata consumed this cycle
//    o_rdata, o_rvalid       : read payload byte and one-cycle valid
//    o_busy                  : frame in progress
//    o_done                  : one-cycle pulse at end of frame
//    o_spi_clk, o_spi_mosi,
//    o_spi_cs, i_spi_miso    : SPI pins (SCLK idles high, CS active-low)
// -----------------------------------------------------------------------------
module spi_wb_host #(
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYCLES  = 4,
   parameter int DUMMY_BYTES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   input  logic [15:0] i_len,
   input  logic [7:0]  i_wdata,
   input  logic        i_wvalid,
   output logic        o_wready,
   output logic [7:0]  o_rdata,
   output logic        o_rvalid,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_spi_clk,
   output logic        o_spi_mosi,
   output logic        o_spi_cs,
   input  logic        i_spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [2:0] HDR_BYTES = 3'd7;

   state_t      state_reg, state_next;
   logic        write_reg, write_next;
   logic [31:0] addr_reg, addr_next;
   logic [15:0] len_reg, len_next;
   logic [2:0]  hdr_reg, hdr_next;     // header bytes already loaded
   logic [16:0] data_reg, data_next;   // data-phase bytes already loaded
   logic [15:0] div_reg, div_next;     // position inside an SCLK half-period
   logic [4:0]  half_reg, half_next;   // SCLK half-period index, 0..16
   logic [15:0] gap_reg, gap_next;
   logic [7:0]  tx_reg, tx_next;       // remaining bits after the one on MOSI
   logic [7:0]  rx_reg, rx_next;
   logic        payrd_reg, payrd_next; // current byte carries read payload
   logic        cs_reg, cs_next;
   logic        sclk_reg, sclk_next;
   logic        mosi_reg, mosi_next;
   logic        rvalid_reg, rvalid_next;
   logic [7:0]  rdata_reg, rdata_next;

   logic        wready;
   logic        load;
   logic        rd_pay;
   logic [7:0]  byte_sel;
   logic [16:0] data_total;

   // 17 bits so len = 0xFFFF plus dummies never wraps
   assign data_total = {1'b0, len_reg} + 17'(DUMMY_BYTES);

   always_comb begin
      state_next  = state_reg;
      write_next  = write_reg;
      addr_next   = addr_reg;
      len_next    = len_reg;
      hdr_next    = hdr_reg;
      data_next   = data_reg;
      div_next    = div_reg;
      half_next   = half_reg;
      gap_next    = gap_reg;
      tx_next     = tx_reg;
      rx_next     = rx_reg;
      payrd_next  = payrd_reg;
      cs_next     = cs_reg;
      sclk_next   = sclk_reg;
      mosi_next   = mosi_reg;
      rvalid_next = 1'b0;
      rdata_next  = rdata_reg;
      wready      = 1'b0;
      load        = 1'b0;
      rd_pay      = 1'b0;
      byte_sel    = 8'h00;

      case (state_reg)
         S_IDLE: begin
            if (i_start) begin
               write_next = i_write;
               addr_next  = i_addr;
               len_next   = i_len;
               hdr_next   = 3'd0;
               data_next  = 17'd0;
               state_next = S_LOAD;
            end
         end

         S_LOAD: begin
            if (hdr_reg != HDR_BYTES) begin
               case (hdr_reg)
                  3'd0:    byte_sel = write_reg ? 8'hA2 : 8'hA1;
                  3'd1:    byte_sel = addr_reg[31:24];
                  3'd2:    byte_sel = addr_reg[23:16];
                  3'd3:    byte_sel = addr_reg[15:8];
                  3'd4:    byte_sel = addr_reg[7:0];
                  3'd5:    byte_sel = len_reg[15:8];
                  3'd6:    byte_sel = len_reg[7:0];
                  default: byte_sel = 8'h00;
               endcase
               hdr_next = hdr_reg + 3'd1;
               load     = 1'b1;
            end else if (write_reg && (data_reg < {1'b0, len_reg})) begin
               // Write payload: wait here (CS/SCLK high) until data is offered
               if (i_wvalid) begin
                  wready    = 1'b1;
                  byte_sel  = i_wdata;
                  data_next = data_reg + 17'd1;
                  load      = 1'b1;
               end
            end else begin
               // Dummy bytes and read slots both send 0x00
               rd_pay    = !write_reg && (data_reg >= 17'(DUMMY_BYTES));
               data_next = data_reg + 17'd1;
               load      = 1'b1;
            end

            if (load) begin
               tx_next    = {byte_sel[6:0], 1'b0};
               mosi_next  = byte_sel[7];
               payrd_next = rd_pay;
               cs_next    = 1'b0;
               sclk_next  = 1'b1;
               div_next   = 16'd0;
               half_next  = 5'd0;
               state_next = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (div_reg == 16'(CLK_DIV - 1)) begin
               div_next  = 16'd0;
               half_next = half_reg + 5'd1;
               if (half_reg == 5'd16) begin
                  cs_next    = 1'b1;
                  sclk_next  = 1'b1;
                  mosi_next  = 1'b0;
                  gap_next   = 16'd0;
                  state_next = S_GAP;
               end else if (!half_reg[0]) begin
                  // Falling edge; bit 0 is already on MOSI since CS fell
                  sclk_next = 1'b0;
                  if (half_reg != 5'd0) begin
                     mosi_next = tx_reg[7];
                     tx_next   = {tx_reg[6:0], 1'b0};
                  end
               end else begin
                  sclk_next = 1'b1;
                  rx_next   = {rx_reg[6:0], i_spi_miso};
               end
            end else begin
               div_next = div_reg + 16'd1;
            end

            // First cycle after the 8th rising edge: byte fully captured
            if ((half_reg == 5'd16) && (div_reg == 16'd0)) begin
               rvalid_next = payrd_reg;
               if (payrd_reg) begin
                  rdata_next = rx_reg;
               end
            end
         end

         S_GAP: begin
            // LOAD adds one more CS-high cycle, so GAP lasts GAP_CYCLES-1
            if (int'(gap_reg) >= GAP_CYCLES - 2) begin
               if ((hdr_reg == HDR_BYTES) && (data_reg == data_total)) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_LOAD;
               end
            end else begin
               gap_next = gap_reg + 16'd1;
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg  <= S_IDLE;
         write_reg  <= 1'b0;
         addr_reg   <= 32'd0;
         len_reg    <= 16'd0;
         hdr_reg    <= 3'd0;
         data_reg   <= 17'd0;
         div_reg    <= 16'd0;
         half_reg   <= 5'd0;
         gap_reg    <= 16'd0;
         tx_reg     <= 8'd0;
         rx_reg     <= 8'd0;
         payrd_reg  <= 1'b0;
         cs_reg     <= 1'b1;
         sclk_reg   <= 1'b1;
         mosi_reg   <= 1'b0;
         rvalid_reg <= 1'b0;
         rdata_reg  <= 8'd0;
      end else begin
         state_reg  <= state_next;
         write_reg  <= write_next;
         addr_reg   <= addr_next;
         len_reg    <= len_next;
         hdr_reg    <= hdr_next;
         data_reg   <= data_next;
         div_reg    <= div_next;
         half_reg   <= half_next;
         gap_reg    <= gap_next;
         tx_reg     <= tx_next;
         rx_reg     <= rx_next;
         payrd_reg  <= payrd_next;
         cs_reg     <= cs_next;
         sclk_reg   <= sclk_next;
         mosi_reg   <= mosi_next;
         rvalid_reg <= rvalid_next;
         rdata_reg  <= rdata_next;
      end
   end

   assign o_wready   = wready;
   assign o_rdata    = rdata_reg;
   assign o_rvalid   = rvalid_reg;
   assign o_busy     = (state_reg == S_LOAD) || (state_reg == S_SHIFT) ||
                       (state_reg == S_GAP);
   assign o_done     = (state_reg == S_DONE);
   assign o_spi_clk  = sclk_reg;
   assign o_spi_mosi = mosi_reg;
   assign o_spi_cs   = cs_reg;

endmodule

// File: tb/tb_spi_wb_host.sv
module tb_spi_wb_host;

   localparam int CLK_DIV     = 4;
   localparam int GAP_CYCLES  = 4;
   localparam int DUMMY_BYTES = 2;
   localparam int BYTE_CYC    = 17 * CLK_DIV + GAP_CYCLES;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_write = 1'b0;
   logic [31:0] i_addr = 32'd0;
   logic [15:0] i_len = 16'd0;
   logic [7:0]  i_wdata = 8'd0;
   logic        i_wvalid = 1'b0;
   logic        o_wready;
   logic [7:0]  o_rdata;
   logic        o_rvalid;
   logic        o_busy;
   logic        o_done;
   logic        o_spi_clk;
   logic        o_spi_mosi;
   logic        o_spi_cs;
   logic        i_spi_miso = 1'b0;

   spi_wb_host #(
      .CLK_DIV    (CLK_DIV),
      .GAP_CYCLES (GAP_CYCLES),
      .DUMMY_BYTES(DUMMY_BYTES)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_write   (i_write),
      .i_addr    (i_addr),
      .i_len     (i_len),
      .i_wdata   (i_wdata),
      .i_wvalid  (i_wvalid),
      .o_wready  (o_wready),
      .o_rdata   (o_rdata),
      .o_rvalid  (o_rvalid),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_spi_clk (o_spi_clk),
      .o_spi_mosi(o_spi_mosi),
      .o_spi_cs  (o_spi_cs),
      .i_spi_miso(i_spi_miso)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_mosi[$];
   logic [7:0] exp_rdata[$];
   logic [7:0] wpay[$];
   logic [7:0] rpay[$];

   int win_cnt, wready_cnt, rvalid_cnt, done_cnt, done_cyc, stall_bad;
   int base_write_cyc;

   // Drives one frame, plays the slave on MISO, and scoreboards every MOSI
   // byte and read byte as it appears. Returns in the o_done cycle, on
   // timeout, or right after raising i_reset when abort is set.
   task automatic run_frame(input logic wr, input logic [31:0] addr,
                            input logic [15:0] len, input int stall_at,
                            input int stall_len, input bit abort,
                            input bit poke, input int max_cyc);
      logic [7:0] miso_sh;
      logic [7:0] mosi_sh;
      logic [7:0] got;
      logic       prev_cs;
      logic       prev_sclk;
      int         cyc, fall_cyc, falls, widx, stall_cnt, pay_lo, slot;
      bit         adv;

      exp_mosi.delete();
      exp_rdata.delete();
      exp_mosi.push_back(wr ? 8'hA2 : 8'hA1);
      for (int i = 3; i >= 0; i--) exp_mosi.push_back(addr[8*i +: 8]);
      exp_mosi.push_back(len[15:8]);
      exp_mosi.push_back(len[7:0]);
      if (wr) begin
         for (int i = 0; i < int'(len); i++) exp_mosi.push_back(wpay[i]);
         for (int i = 0; i < DUMMY_BYTES; i++) exp_mosi.push_back(8'h00);
      end else begin
         for (int i = 0; i < DUMMY_BYTES + int'(len); i++) exp_mosi.push_back(8'h00);
         for (int i = 0; i < int'(len); i++) exp_rdata.push_back(rpay[i]);
      end

      win_cnt = 0; wready_cnt = 0; rvalid_cnt = 0; done_cnt = 0;
      done_cyc = 0; stall_bad = 0;
      prev_cs = 1'b1; prev_sclk = 1'b1;
      cyc = 0; fall_cyc = 0; falls = 0; widx = 0; stall_cnt = 0; adv = 1'b0;
      miso_sh = 8'h00; mosi_sh = 8'h00;
      pay_lo = 7 + DUMMY_BYTES;

      @(negedge i_clk);
      i_start  = 1'b1;
      i_write  = wr;
      i_addr   = addr;
      i_len    = len;
      i_wdata  = (wr && len != 16'd0) ? wpay[0] : 8'h00;
      i_wvalid = wr && (len != 16'd0);

      forever begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (poke && cyc == 200) begin
            i_start = 1'b1;
            i_addr  = 32'hDEADBEEF;
            i_write = ~wr;
            i_len   = 16'd9;
         end
         if (adv) begin
            widx++;
            adv = 1'b0;
         end
         if (stall_cnt > 0) stall_cnt--;
         i_wvalid = wr && (widx < int'(len)) && (stall_cnt == 0);
         i_wdata  = (wr && widx < int'(len)) ? wpay[widx] : 8'h00;
         #1;
         cyc++;

         if (o_wready) begin
            wready_cnt++;
            adv = 1'b1;
         end
         if (stall_cnt > 0 && !(o_spi_cs && o_spi_clk)) stall_bad++;

         if (prev_cs && !o_spi_cs) begin
            win_cnt++;
            fall_cyc = cyc;
            falls    = 0;
            mosi_sh  = 8'h00;
            slot     = win_cnt - 1;
            miso_sh  = (!wr && slot >= pay_lo && slot < pay_lo + int'(len)) ?
                       rpay[slot - pay_lo] : 8'h5A;
            i_spi_miso = miso_sh[7];
         end
         if (!o_spi_cs && prev_sclk && !o_spi_clk) begin
            falls++;
            if (falls > 1) begin
               miso_sh    = {miso_sh[6:0], 1'b0};
               i_spi_miso = miso_sh[7];
            end
            if (abort && win_cnt == 2 && falls == 4) begin
               i_reset = 1'b1;
               return;
            end
         end
         if (!o_spi_cs && !prev_sclk && o_spi_clk) mosi_sh = {mosi_sh[6:0], o_spi_mosi};

         if (!prev_cs && o_spi_cs) begin
            n_checks++;
            if (cyc - fall_cyc != 17 * CLK_DIV) begin
               n_fail++;
               $display("FAIL cs_width byte %0d: got %0d cycles, expected %0d", win_cnt, cyc - fall_cyc, 17 * CLK_DIV);
            end
            n_checks++;
            if (exp_mosi.size() == 0) begin
               n_fail++;
               $display("FAIL mosi_extra byte %0d: got %02h, expected no byte", win_cnt, mosi_sh);
            end else begin
               got = exp_mosi.pop_front();
               if (mosi_sh !== got) begin
                  n_fail++;
                  $display("FAIL mosi byte %0d: got %02h, expected %02h", win_cnt, mosi_sh, got);
               end
            end
            if (stall_at >= 0 && win_cnt == 7 + stall_at) stall_cnt = stall_len + 3;
         end

         if (o_rvalid) begin
            rvalid_cnt++;
            n_checks++;
            if (exp_rdata.size() == 0) begin
               n_fail++;
               $display("FAIL rdata_extra: got %02h, expected no rvalid", o_rdata);
            end else begin
               got = exp_rdata.pop_front();
               if (o_rdata !== got) begin
                  n_fail++;
                  $display("FAIL rdata %0d: got %02h, expected %02h", rvalid_cnt, o_rdata, got);
               end
            end
         end

         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            n_checks++;
            if (o_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_in_done: got %b, expected 0", o_busy);
            end
            $display("frame wr=%0b addr=%08h len=%0d done at cycle %0d, %0d bytes", wr, addr, len, cyc, win_cnt);
            return;
         end
         if (cyc >= max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no o_done after %0d cycles, expected one", cyc);
            return;
         end
         prev_cs   = o_spi_cs;
         prev_sclk = o_spi_clk;
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      #1;
      n_checks++; if (o_spi_cs !== 1'b1)   begin n_fail++; $display("FAIL reset_cs: got %b, expected 1", o_spi_cs); end
      n_checks++; if (o_spi_clk !== 1'b1)  begin n_fail++; $display("FAIL reset_sclk: got %b, expected 1", o_spi_clk); end
      n_checks++; if (o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b, expected 0", o_spi_mosi); end
      n_checks++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
      n_checks++; if (o_done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b, expected 0", o_done); end
      n_checks++; if (o_wready !== 1'b0)   begin n_fail++; $display("FAIL reset_wready: got %b, expected 0", o_wready); end
      n_checks++; if (o_rvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_rvalid: got %b, expected 0", o_rvalid); end
      n_checks++; if (o_rdata !== 8'h00)   begin n_fail++; $display("FAIL reset_rdata: got %02h, expected 00", o_rdata); end
      i_reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_read();
      rpay = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_frame(1'b0, 32'h11223344, 16'd4, -1, 0, 1'b0, 1'b0, 3000);
      n_checks++; if (win_cnt != 13)   begin n_fail++; $display("FAIL read_windows: got %0d, expected 13", win_cnt); end
      n_checks++; if (rvalid_cnt != 4) begin n_fail++; $display("FAIL read_rvalid_cnt: got %0d, expected 4", rvalid_cnt); end
      n_checks++; if (wready_cnt != 0) begin n_fail++; $display("FAIL read_wready_cnt: got %0d, expected 0", wready_cnt); end
      n_checks++; if (done_cnt != 1)   begin n_fail++; $display("FAIL read_done_cnt: got %0d, expected 1", done_cnt); end
      n_checks++; if (done_cyc < 13*BYTE_CYC-2 || done_cyc > 13*BYTE_CYC+2) begin n_fail++; $display("FAIL read_done_time: got %0d, expected %0d +-2", done_cyc, 13*BYTE_CYC); end
      n_checks++; if (exp_mosi.size() != 0 || exp_rdata.size() != 0) begin n_fail++; $display("FAIL read_leftover: got %0d/%0d bytes unseen, expected 0/0", exp_mosi.size(), exp_rdata.size()); end
   endtask

   task automatic test_write();
      wpay = '{8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(1'b1, 32'h11223344, 16'd4, -1, 0, 1'b0, 1'b0, 3000);
      base_write_cyc = done_cyc;
      n_checks++; if (win_cnt != 13)   begin n_fail++; $display("FAIL write_windows: got %0d, expected 13", win_cnt); end
      n_checks++; if (wready_cnt != 4) begin n_fail++; $display("FAIL write_wready_cnt: got %0d, expected 4", wready_cnt); end
      n_checks++; if (rvalid_cnt != 0) begin n_fail++; $display("FAIL write_rvalid_cnt: got %0d, expected 0", rvalid_cnt); end
      n_checks++; if (done_cyc < 13*BYTE_CYC-2 || done_cyc > 13*BYTE_CYC+2) begin n_fail++; $display("FAIL write_done_time: got %0d, expected %0d +-2", done_cyc, 13*BYTE_CYC); end
      n_checks++; if (exp_mosi.size() != 0) begin n_fail++; $display("FAIL write_leftover: got %0d bytes unseen, expected 0", exp_mosi.size()); end
   endtask

   task automatic test_write_stall();
      wpay = '{8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(1'b1, 32'h11223344, 16'd4, 2, 100, 1'b0, 1'b0, 3000);
      n_checks++; if (stall_bad != 0)  begin n_fail++; $display("FAIL stall_pins: got %0d cycles with CS or SCLK low, expected 0", stall_bad); end
      n_checks++; if (wready_cnt != 4) begin n_fail++; $display("FAIL stall_wready_cnt: got %0d, expected 4", wready_cnt); end
      n_checks++; if (win_cnt != 13)   begin n_fail++; $display("FAIL stall_windows: got %0d, expected 13", win_cnt); end
      n_checks++; if (done_cyc < base_write_cyc+98 || done_cyc > base_write_cyc+102) begin n_fail++; $display("FAIL stall_done_time: got %0d, expected %0d +-2", done_cyc, base_write_cyc+100); end
      n_checks++; if (exp_mosi.size() != 0) begin n_fail++; $display("FAIL stall_leftover: got %0d bytes unseen, expected 0", exp_mosi.size()); end
   endtask

   task automatic test_len0();
      run_frame(1'b0, 32'hCAFEF00D, 16'd0, -1, 0, 1'b0, 1'b0, 3000);
      n_checks++; if (win_cnt != 9)    begin n_fail++; $display("FAIL len0_windows: got %0d, expected 9", win_cnt); end
      n_checks++; if (rvalid_cnt != 0) begin n_fail++; $display("FAIL len0_rvalid_cnt: got %0d, expected 0", rvalid_cnt); end
      n_checks++; if (done_cnt != 1)   begin n_fail++; $display("FAIL len0_done_cnt: got %0d, expected 1", done_cnt); end
      n_checks++; if (done_cyc < 9*BYTE_CYC-2 || done_cyc > 9*BYTE_CYC+2) begin n_fail++; $display("FAIL len0_done_time: got %0d, expected %0d +-2", done_cyc, 9*BYTE_CYC); end
      // i_start offered during the DONE cycle must be ignored
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      #1;
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done: got busy %b, expected 0", o_busy); end
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      bit saw_bad;
      rpay = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_frame(1'b0, 32'h11223344, 16'd4, -1, 0, 1'b1, 1'b0, 3000);
      n_checks++; if (done_cnt != 0 || i_reset !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got done_cnt %0d reset %b, expected 0 and 1", done_cnt, i_reset); end
      @(negedge i_clk);
      #1;
      i_reset = 1'b0;
      n_checks++; if (o_spi_cs !== 1'b1)   begin n_fail++; $display("FAIL midrst_cs: got %b, expected 1", o_spi_cs); end
      n_checks++; if (o_spi_clk !== 1'b1)  begin n_fail++; $display("FAIL midrst_sclk: got %b, expected 1", o_spi_clk); end
      n_checks++; if (o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL midrst_mosi: got %b, expected 0", o_spi_mosi); end
      n_checks++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", o_busy); end
      saw_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (o_done !== 1'b0 || o_busy !== 1'b0 || o_spi_cs !== 1'b1) saw_bad = 1'b1;
         @(negedge i_clk);
         #1;
      end
      n_checks++; if (saw_bad) begin n_fail++; $display("FAIL midrst_idle: got activity after reset, expected idle pins and no done"); end
      run_frame(1'b0, 32'h11223344, 16'd4, -1, 0, 1'b0, 1'b0, 3000);
      n_checks++; if (win_cnt != 13 || rvalid_cnt != 4 || done_cnt != 1) begin n_fail++; $display("FAIL midrst_reframe: got win %0d rvalid %0d done %0d, expected 13 4 1", win_cnt, rvalid_cnt, done_cnt); end
      n_checks++; if (exp_mosi.size() != 0 || exp_rdata.size() != 0) begin n_fail++; $display("FAIL midrst_leftover: got %0d/%0d unseen, expected 0/0", exp_mosi.size(), exp_rdata.size()); end
   endtask

   task automatic test_start_while_busy();
      rpay = '{8'h01, 8'h23, 8'h45, 8'h67};
      run_frame(1'b0, 32'h11223344, 16'd4, -1, 0, 1'b0, 1'b1, 3000);
      n_checks++; if (win_cnt != 13 || done_cnt != 1) begin n_fail++; $display("FAIL busy_start_frame: got win %0d done %0d, expected 13 1", win_cnt, done_cnt); end
      n_checks++; if (rvalid_cnt != 4) begin n_fail++; $display("FAIL busy_start_rvalid: got %0d, expected 4", rvalid_cnt); end
      n_checks++; if (done_cyc < 13*BYTE_CYC-2 || done_cyc > 13*BYTE_CYC+2) begin n_fail++; $display("FAIL busy_start_time: got %0d, expected %0d +-2", done_cyc, 13*BYTE_CYC); end
      n_checks++; if (exp_mosi.size() != 0 || exp_rdata.size() != 0) begin n_fail++; $display("FAIL busy_start_leftover: got %0d/%0d unseen, expected 0/0", exp_mosi.size(), exp_rdata.size()); end
      @(negedge i_clk);
      #1;
      n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got busy %b, expected 0", o_busy); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_write_stall();
      test_len0();
      test_reset_mid_frame();
      test_start_while_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_wb_host.md
Name: spi_wb_host

Overview:
- SPI master that issues framed bus transactions to the SPI-to-Wishbone slave bridge. It is the host end of the same protocol.
- Frame format:
  - Command byte: 0xA1 for read, 0xA2 for write.
  - 32-bit address, MSB first.
  - 16-bit length, MSB first.
  - Data phase of length plus DUMMY_BYTES bytes.
- Used by on-chip controllers and loopback benches to drive the bridge without an external host.
- Chip select drops and rises once per byte, matching the bridge's byte framing.

Parameters:
- CLK_DIV, 4: SCLK half-period in i_clk cycles, ≥2.
- GAP_CYCLES, 4: i_clk cycles CS stays high between bytes, ≥1.
- DUMMY_BYTES, 2: extra 0x00 bytes in the data phase, 0..7.

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: synchronous reset, active-high.
- i_start, input, 1: start a transaction when idle.
- i_write, input, 1: 1 = write (0xA2), 0 = read (0xA1); sampled with i_start.
- i_addr, input, 32: bus address; sampled with i_start.
- i_len, input, 16: payload byte count; sampled with i_start.
- i_wdata, input, 8: write payload byte.
- i_wvalid, input, 1: i_wdata valid.
- o_wready, output, 1: one-cycle pulse; i_wdata consumed this cycle.
- o_rdata, output, 8: read payload byte.
- o_rvalid, output, 1: one-cycle pulse; o_rdata valid.
- o_busy, output, 1: transaction in progress.
- o_done, output, 1: one-cycle pulse at end of frame.
- o_spi_clk, output, 1: SCLK; idles high.
- o_spi_mosi, output, 1: MOSI.
- o_spi_cs, output, 1: chip select, active-low.
- i_spi_miso, input, 1: MISO.

Behaviour:
- Reset values:
  - o_spi_cs=1, o_spi_clk=1, o_spi_mosi=0.
  - o_busy=0, o_done=0, o_wready=0, o_rvalid=0, o_rdata=0.
- Reset asserted mid-frame forces these values on the next edge and abandons the frame with no o_done.
- SPI mode 3 (CPOL=1, CPHA=1), MSB first. MOSI changes on SCLK falling edges; MISO is sampled on rising edges.
- Per-byte timing, with D=CLK_DIV and t0 = the cycle CS falls:
  - At t0, MOSI = b7 and SCLK stays high.
  - Bit k (k=0..7): SCLK low on [t0+(2k+1)D, t0+(2k+2)D), high otherwise. MOSI = b(7-k) from that falling edge.
  - MISO is registered at each SCLK rising edge into bit 7-k.
  - CS rises at t0+17D. MOSI returns to 0 at the same time.
  - The next byte's CS falls no earlier than GAP_CYCLES cycles later.
  - Byte period = 17D + GAP_CYCLES, 72 cycles at defaults.
- States:
  - IDLE: on i_start, latch inputs, o_busy=1, go to LOAD.
  - LOAD: select the next byte from the sequence below.
  - SHIFT: 8 bits.
  - GAP: from GAP go to LOAD, or to DONE after the last byte.
  - DONE: o_done=1 for one cycle, o_busy=0 in that same cycle, return to IDLE.
- Byte sequence: cmd, addr[31:24], addr[23:16], addr[15:8], addr[7:0], len[15:8], len[7:0], then the data phase.
- Read data phase:
  - DUMMY_BYTES bytes of 0x00 first; their MISO is discarded.
  - Then len bytes of 0x00. The captured MISO byte is presented on o_rdata with o_rvalid for one cycle, one cycle after the 8th rising edge.
- Write data phase:
  - len payload bytes, then DUMMY_BYTES bytes of 0x00.
  - In LOAD for a payload byte: if i_wvalid=1, pulse o_wready and latch i_wdata. Otherwise stay in LOAD with CS high and SCLK high; the gap stretches.
- i_len=0: the frame is header plus DUMMY_BYTES only. No o_wready or o_rvalid pulses.
- i_len=0xFFFF: data counter is 17 bits, no wrap.
- i_start while o_busy=1 is ignored. i_start in the DONE cycle is ignored; a new frame is accepted from the next cycle.
- Inputs are latched only at start. Changes to i_addr, i_len, i_write mid-frame have no effect.

Test Plan:
- Read: i_write=0, addr 0x11223344, len 4, slave model returns 0xCC,0xDD,0xEE,0xFF in payload slots.
  - MOSI bytes: A1 11 22 33 44 00 04 00×6.
  - 4 o_rvalid pulses with CC DD EE FF.
  - 13 CS-low windows, each 17×4 cycles wide.
  - o_done at 936 cycles after start, ±2.
- Write: addr 0x11223344, len 4, wdata 55 66 77 88, i_wvalid held high.
  - MOSI: A2 11 22 33 44 00 04 55 66 77 88 00 00.
  - Exactly 4 o_wready pulses.
- Write stall: drop i_wvalid for 100 cycles before the 3rd payload byte.
  - CS and SCLK stay high for the whole stall.
  - MOSI byte stream unchanged; frame ends 100 cycles later than the unstalled case.
- Length 0 read: only 7 header bytes + 2 dummies.
  - No o_rvalid pulses; o_done asserts once.
- Reset mid-frame: assert i_reset during the 4th bit of the address byte.
  - Next cycle: CS=1, SCLK=1, o_busy=0, no o_done.
  - A new i_start then produces a full, correct frame.
- i_start pulsed while busy with different addr: ignored; the original frame bytes are unchanged.
